// File: rtl/serial_mul_if.sv
// Operand and product valid/ready channels of the serial multiplier.
// The multiplier uses the slave modport; the producer/consumer uses master.
interface serial_mul_if #(
    parameter int unsigned Width = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [Width-1:0]   a;
    logic [Width-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*Width-1:0] result;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result
    );
endinterface

// File: rtl/serial_mul.sv
// Radix-2 shift-and-add unsigned multiplier, one multiplier bit per cycle.
// Optional SERIAL_MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier is zero.
module serial_mul #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    output logic             busy,
    serial_mul_if.slave      bus
);

    localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*Width-1:0]   acc_q, acc_d;
    logic [2*Width-1:0]   mcand_q, mcand_d;
    logic [Width-1:0]     mplier_q, mplier_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 last_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        last_step = 1'b0;
        // Flush keeps the datapath as-is; only the FSM returns to idle.
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        acc_d    = '0;
                        mcand_d  = {{Width{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        cnt_d    = '0;
                        state_d  = StRun;
                    end
                end
                StRun: begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d   = mcand_q << 1;
                    mplier_d  = mplier_q >> 1;
                    cnt_d     = cnt_q + CntW'(1);
                    last_step = (cnt_q == CntW'(Width - 1));
`ifdef SERIAL_MUL_EARLY_TERM_EN
                    last_step = last_step | (mplier_d == '0);
`endif
                    if (last_step) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == StIdle) & ~rst;
        bus.out_valid = (state_q == StDone);
        bus.result    = acc_q;
        busy          = (state_q == StRun);
    end

endmodule

// File: tb/tb_serial_mul.sv
// Directed, table-driven bench for serial_mul at Width=8, plus flush/reset/backpressure
// sequences. Latency expectations follow SERIAL_MUL_EARLY_TERM_EN as compiled.
module tb_serial_mul;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    logic flush;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    serial_mul_if #(.Width(W)) bus ();

    serial_mul #(.Width(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        int             lat_full;
        int             lat_early;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int pick_lat(input int lat_full, input int lat_early);
`ifdef SERIAL_MUL_EARLY_TERM_EN
        pick_lat = lat_early;
`else
        pick_lat = lat_full;
`endif
    endfunction

    // Issue one operation at a negedge; returns product, edges from accept to valid, busy cycles.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] res, output int lat, output int busy_cnt);
        int k;
        k = 0;
        while (!bus.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("in_ready before issue", {63'd0, bus.in_ready}, 64'd1);
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        res      = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (bus.out_valid) begin
                lat = i - 1;
                res = bus.result;
                break;
            end
        end
        @(negedge clk);
    endtask

    logic [2*W-1:0] res;
    int lat;
    int bcnt;
    int k;

    initial begin
        vecs[0] = '{a: 8'd13,  b: 8'd11,  prod: 16'd143,   lat_full: 8, lat_early: 4};
        vecs[1] = '{a: 8'd255, b: 8'd255, prod: 16'hFE01,  lat_full: 8, lat_early: 8};
        vecs[2] = '{a: 8'hAB,  b: 8'd0,   prod: 16'd0,     lat_full: 8, lat_early: 1};
        vecs[3] = '{a: 8'd0,   b: 8'hFF,  prod: 16'd0,     lat_full: 8, lat_early: 8};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   prod: 16'd1,     lat_full: 8, lat_early: 1};
        vecs[5] = '{a: 8'd6,   b: 8'd7,   prod: 16'd42,    lat_full: 8, lat_early: 3};
        vecs[6] = '{a: 8'd255, b: 8'd1,   prod: 16'd255,   lat_full: 8, lat_early: 1};
        vecs[7] = '{a: 8'd128, b: 8'd2,   prod: 16'd256,   lat_full: 8, lat_early: 2};
        vecs[8] = '{a: 8'd200, b: 8'd100, prod: 16'd20000, lat_full: 8, lat_early: 7};

        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset result",    {48'd0, bus.result},    64'd0);
        check("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset busy",      {63'd0, busy},          64'd0);
        check("reset in_ready",  {63'd0, bus.in_ready},  64'd0);
        rst = 1'b0;
        #1 check("in_ready after reset", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, res, lat, bcnt);
            check($sformatf("vec%0d product", i), {48'd0, res}, {48'd0, vecs[i].prod});
            check($sformatf("vec%0d latency", i), 64'(lat),
                  64'(pick_lat(vecs[i].lat_full, vecs[i].lat_early)));
            check($sformatf("vec%0d busy cycles", i), 64'(bcnt),
                  64'(pick_lat(vecs[i].lat_full, vecs[i].lat_early)));
        end

        // Backpressure: 7*9 held in DONE for 5 cycles.
        bus.a = 8'd7; bus.b = 8'd9; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("bp valid reached", {63'd0, bus.out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp result",    {48'd0, bus.result},    64'd63);
            check("bp out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("bp in_ready",  {63'd0, bus.in_ready},  64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp released out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("bp released in_ready",  {63'd0, bus.in_ready},  64'd1);

        // Flush in the 3rd RUN cycle of 200*100.
        bus.a = 8'd200; bus.b = 8'd100; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("flush busy before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy",      {63'd0, busy},          64'd0);
        check("flush in_ready",  {63'd0, bus.in_ready},  64'd1);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid || busy) k++;
        end
        check("flush no activity", 64'(k), 64'd0);
        do_op(8'd6, 8'd7, res, lat, bcnt);
        check("post-flush product", {48'd0, res}, 64'd42);

        // Flush together with in_valid in IDLE must not accept.
        bus.a = 8'd3; bus.b = 8'd3; bus.in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; flush = 1'b0;
        check("flush blocks accept", {63'd0, busy}, 64'd0);
        @(negedge clk);

        // Reset in the 4th RUN cycle.
        bus.a = 8'd255; bus.b = 8'd255; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst-run out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst-run busy",      {63'd0, busy},          64'd0);
        check("rst-run result",    {48'd0, bus.result},    64'd0);
        check("rst-run in_ready",  {63'd0, bus.in_ready},  64'd0);
        rst = 1'b0;
        #1 check("rst-run in_ready low rst", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        do_op(8'd3, 8'd5, res, lat, bcnt);
        check("post-reset product", {48'd0, res}, 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
